ip_uart_rx_inst: RTL and testbench

- Z80 I/O-mapped UART receiver, 8N1, with a receive FIFO.
- Sits upstream of the CPU: it converts the serial uart_rx pin into bytes and drives them onto the Z80 data bus on I/O reads.
- Companion to the existing transmit-side UART peripheral; shares the same clock, reset and I/O bus signals.
- The top level muxes q onto d when q_en is high.

---
 rtl/ip_uart_rx_inst.sv | 209 ++++++++++++++++++++
 tb/tb_ip_uart_rx_inst.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ip_uart_rx_inst.sv
// ip_uart_rx_inst
// Z80 I/O-mapped 8N1 UART receiver with a receive FIFO.
//
// Serial bytes arriving on uart_rx are framed by a small RX state machine
// and pushed into a circular FIFO. The CPU reads two I/O ports:
//   io_address     status: {4'b0, ferr, ovr, full, not_empty}
//   io_address + 1 data  : FIFO head (8'hFF when empty), popped at end of access
//
// Handshake: an access is active while !iorq_n && !rd_n && a matches a port.
// q_en rises one clk after the access starts and falls one clk after it ends.
// q is valid whenever q_en is high, and is 8'h00 otherwise.
// A data read pops exactly once, on the clk where the access ends.
// A status read clears ovr/ferr on that same clk. A new event wins over the clear.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   iorq_n   Z80 I/O request (active low)
//   rd_n     Z80 read strobe (active low)
//   a        Z80 address, low byte
//   q        read data toward the bus
//   q_en     high while q must drive the bus
//   uart_rx  serial input, idle high, asynchronous to clk
module ip_uart_rx_inst #(
    parameter int          clk_freq        = 86400000,
    parameter int          uart_freq       = 115200,
    parameter logic [7:0]  io_address      = 8'h10,
    parameter int          fifo_depth_log2 = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic [7:0] a,
    output logic [7:0] q,
    output logic       q_en,
    input  logic       uart_rx
);

    localparam int BIT_PERIOD  = clk_freq / uart_freq;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int TW          = $clog2(BIT_PERIOD);
    localparam int DEPTH       = 1 << fifo_depth_log2;
    localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_PERIOD - 1);
    localparam logic [7:0]    DATA_ADDR = io_address + 8'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // ---------------- input synchroniser + edge detect ----------------
    logic sync1, sync2, rx_prev;
    logic rx_s, rx_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign rx_s    = sync2;
    assign rx_fall = rx_prev & ~rx_s;

    // ---------------- RX state machine ----------------
    rx_state_t     state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    shreg, shreg_d;
    logic [2:0]    bitcnt, bitcnt_d;
    logic          armed, armed_d;   // low after a framing error until the line idles high
    logic          frame_ok, frame_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            timer  <= '0;
            shreg  <= '0;
            bitcnt <= '0;
            armed  <= 1'b1;
        end else begin
            state  <= state_d;
            timer  <= timer_d;
            shreg  <= shreg_d;
            bitcnt <= bitcnt_d;
            armed  <= armed_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        shreg_d   = shreg;
        bitcnt_d  = bitcnt;
        armed_d   = armed;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (rx_s) armed_d = 1'b1;
                if (armed && rx_fall) begin
                    timer_d = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (timer != '0) begin
                    timer_d = timer - 1'b1;
                end else if (!rx_s) begin
                    timer_d  = BIT_LOAD;
                    bitcnt_d = '0;
                    state_d  = DATA;
                end else begin
                    state_d = IDLE;          // glitch, not a start bit
                end
            end
            DATA: begin
                if (timer != '0) begin
                    timer_d = timer - 1'b1;
                end else begin
                    shreg_d  = {rx_s, shreg[7:1]};
                    timer_d  = BIT_LOAD;
                    bitcnt_d = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (timer != '0) begin
                    timer_d = timer - 1'b1;
                end else begin
                    state_d = IDLE;
                    if (rx_s) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                        armed_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- I/O decode ----------------
    logic acc_st, acc_dt, acc_st_q, acc_dt_q, dt_hit;
    logic st_end, pop;

    assign acc_st = !iorq_n && !rd_n && (a == io_address);
    assign acc_dt = !iorq_n && !rd_n && (a == DATA_ADDR);
    assign st_end = acc_st_q && !acc_st;
    // dt_hit remembers whether the access saw data, so an empty read never pops
    assign pop    = acc_dt_q && !acc_dt && dt_hit;

    // ---------------- FIFO ----------------
    logic [7:0]               mem [DEPTH];
    logic [fifo_depth_log2:0] wptr, rptr;
    logic                     full, empty, push, ovr_set;
    logic                     ovr, ferr;
    logic [7:0]               status;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[fifo_depth_log2] != rptr[fifo_depth_log2]) &&
                     (wptr[fifo_depth_log2-1:0] == rptr[fifo_depth_log2-1:0]);
    // a pop on the same clk frees a slot, so a full FIFO still accepts the byte
    assign push    = frame_ok && (!full || pop);
    assign ovr_set = frame_ok && full && !pop;
    assign status  = {4'b0000, ferr, ovr, full, !empty};

    always_ff @(posedge clk) begin
        if (push) mem[wptr[fifo_depth_log2-1:0]] <= shreg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
            acc_st_q <= 1'b0;
            acc_dt_q <= 1'b0;
            dt_hit   <= 1'b0;
            q        <= 8'h00;
            q_en     <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            ovr  <= ovr_set   | (ovr  & ~st_end);
            ferr <= frame_bad | (ferr & ~st_end);

            acc_st_q <= acc_st;
            acc_dt_q <= acc_dt;
            q_en     <= acc_st | acc_dt;

            if (acc_st) begin
                q <= status;
            end else if (acc_dt && !acc_dt_q) begin
                // data is captured once at the start and held for the access
                q      <= empty ? 8'hFF : mem[rptr[fifo_depth_log2-1:0]];
                dt_hit <= !empty;
            end else if (!acc_dt) begin
                q <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_ip_uart_rx_inst.sv
// Directed testbench for ip_uart_rx_inst.
// The receiver is built with a 32-clk bit period (half period 16) so that the
// whole sequence, including the 17-byte overflow case, stays short.
module tb_ip_uart_rx_inst;

    localparam int BP = 32;
    localparam logic [7:0] ST = 8'h10;
    localparam logic [7:0] DT = 8'h11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       iorq_n = 1'b1;
    logic       rd_n = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] q;
    logic       q_en;
    logic       uart_rx = 1'b1;

    int passes = 0;
    int total  = 0;

    ip_uart_rx_inst #(
        .clk_freq       (115200 * BP),
        .uart_freq      (115200),
        .io_address     (8'h10),
        .fifo_depth_log2(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .iorq_n (iorq_n),
        .rd_n   (rd_n),
        .a      (a),
        .q      (q),
        .q_en   (q_en),
        .uart_rx(uart_rx)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, observed=running expected=done");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (BP) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BP) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // read held for 'hold' clocks; q and q_en checked every clock of the access
    task automatic io_rd(input logic [7:0] addr, input int hold, input string tag,
                         input logic [7:0] exp);
        @(negedge clk);
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        a      = addr;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_qen"}, {7'd0, q_en}, 8'h01);
            check(tag, q, exp);
        end
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        a      = 8'h00;
        @(negedge clk);
        check({tag, "_qen_off"}, {7'd0, q_en}, 8'h00);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset
        repeat (3) @(negedge clk);
        check("rst_q", q, 8'h00);
        check("rst_qen", {7'd0, q_en}, 8'h00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // idle line
        io_rd(ST, 1, "idle_status", 8'h00);
        io_rd(DT, 1, "idle_data", 8'hFF);

        // a write cycle must not drive the bus
        iorq_n = 1'b0;
        a      = DT;
        repeat (2) @(negedge clk);
        check("write_qen", {7'd0, q_en}, 8'h00);
        iorq_n = 1'b1;
        a      = 8'h00;

        // single byte
        send_byte(8'hA5, 1'b1);
        io_rd(ST, 1, "a5_status", 8'h01);
        io_rd(DT, 1, "a5_data", 8'hA5);
        io_rd(ST, 1, "a5_status_after", 8'h00);

        // overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        // full FIFO is also non-empty: not_empty | full | ovr
        io_rd(ST, 1, "ovr_status", 8'h07);
        for (int i = 0; i < 16; i++) io_rd(DT, 1, "ovr_data", 8'(i));
        io_rd(ST, 1, "ovr_status_after", 8'h00);

        // framing error
        send_byte(8'h3C, 1'b0);
        repeat (2 * BP) @(negedge clk);
        io_rd(ST, 1, "ferr_status", 8'h08);
        io_rd(ST, 1, "ferr_status_after", 8'h00);
        io_rd(DT, 1, "ferr_data", 8'hFF);

        // short glitch, less than half a bit
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BP / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * BP) @(negedge clk);
        io_rd(ST, 1, "glitch_status", 8'h00);

        // long data read pops once
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        io_rd(DT, 20, "long_data", 8'h11);
        io_rd(ST, 1, "long_status", 8'h01);
        io_rd(DT, 1, "long_data2", 8'h22);
        io_rd(ST, 1, "long_status_after", 8'h00);

        // reset during data bit 4
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'b1;
            repeat (BP) @(negedge clk);
        end
        uart_rx = 1'b0;
        repeat (BP / 2) @(negedge clk);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_q", q, 8'h00);
        check("midrst_qen", {7'd0, q_en}, 8'h00);
        reset_n = 1'b1;
        repeat (3 * BP) @(negedge clk);
        io_rd(ST, 1, "midrst_status", 8'h00);
        send_byte(8'h5A, 1'b1);
        io_rd(ST, 1, "midrst_5a_status", 8'h01);
        io_rd(DT, 1, "midrst_5a_data", 8'h5A);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
